// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU (requester 0)
// and the DMA/loader (requester 1), with bounded bursts and per-requester read return.
module mem_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        conflict_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic       owner_reg, owner_next;
  logic [3:0] burst_reg, burst_next;
  logic       rd_pend_reg, rd_pend_next;
  logic       rd_who_reg, rd_who_next;
  logic [7:0] conflict_reg, conflict_next;

  logic       both_req;
  logic       keep_owner;
  logic [1:0] rvalid_vec;
  logic [DATA_W-1:0] rdata_vec [2];

  assign both_req = cpu_req & dma_req;

  // burst==0 only occurs straight after reset: no streak is held yet, so the
  // non-owner (the CPU) takes the first contention.
  assign keep_owner = (burst_reg != 4'd0) && (burst_reg < BURST_LIM);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (both_req) begin
        if (keep_owner) begin
          cpu_gnt = ~owner_reg;
          dma_gnt = owner_reg;
        end else begin
          cpu_gnt = owner_reg;
          dma_gnt = ~owner_reg;
        end
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    owner_next    = owner_reg;
    burst_next    = burst_reg;
    rd_pend_next  = mem_en & ~mem_we;
    rd_who_next   = dma_gnt;
    conflict_next = conflict_reg;
    if (mem_en) begin
      if (dma_gnt == owner_reg) begin
        burst_next = (burst_reg == 4'hF) ? 4'hF : burst_reg + 4'd1;
      end else begin
        owner_next = dma_gnt;
        burst_next = 4'd1;
      end
    end
    if (both_req && conflict_reg != 8'hFF) begin
      conflict_next = conflict_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg    <= 1'b1;
      burst_reg    <= 4'd0;
      rd_pend_reg  <= 1'b0;
      rd_who_reg   <= 1'b0;
      conflict_reg <= 8'd0;
    end else begin
      owner_reg    <= owner_next;
      burst_reg    <= burst_next;
      rd_pend_reg  <= rd_pend_next;
      rd_who_reg   <= rd_who_next;
      conflict_reg <= conflict_next;
    end
  end

  // Gating with reset drops a read return that collides with a reset cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid_vec[gi] = rd_pend_reg & (rd_who_reg == 1'(gi)) & ~reset;
    assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
  end

  assign cpu_rvalid   = rvalid_vec[0];
  assign dma_rvalid   = rvalid_vec[1];
  assign cpu_rdata    = rdata_vec[0];
  assign dma_rdata    = rdata_vec[1];
  assign conflict_cnt = conflict_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model predicts
// grants, memory strobes, read returns and the conflict count every cycle.
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic          mem_en, mem_we;
  logic [7:0]    conflict_cnt;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro stand-in: one-cycle registered read.
  logic [DW-1:0] mem [32];
  logic          load_en;
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h10 + i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [32];
  int            m_owner, m_streak, m_conf;
  bit            m_pend;
  int            m_pend_who;
  logic [DW-1:0] m_pend_data;
  int            last_win;

  // Requester transaction state (held until granted)
  bit            c_act, d_act;
  logic          c_we, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wd, d_wd;

  task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!c_act) begin c_act = 1; c_we = we; c_addr = a; c_wd = d; end
  endtask

  task automatic dma_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!d_act) begin d_act = 1; d_we = we; d_addr = a; d_wd = d; end
  endtask

  task automatic step(input bit rst);
    int win;
    bit both, exp_v, exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    reset     = rst;
    cpu_req   = c_act; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dma_req   = d_act; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    #1;
    both = c_act && d_act;
    if (rst)        win = -1;
    else if (both)  win = (m_streak > 0 && m_streak < MB) ? m_owner : 1 - m_owner;
    else if (c_act) win = 0;
    else if (d_act) win = 1;
    else            win = -1;
    exp_we = 0; exp_a = '0; exp_d = '0;
    if (win == 0) begin exp_we = c_we; exp_a = c_addr; exp_d = c_wd; end
    if (win == 1) begin exp_we = d_we; exp_a = d_addr; exp_d = d_wd; end
    check("cpu_gnt", 32'(cpu_gnt), 32'(win == 0));
    check("dma_gnt", 32'(dma_gnt), 32'(win == 1));
    check("mem_en", 32'(mem_en), 32'(win >= 0));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(exp_a));
    check("mem_wdata", 32'(mem_wdata), 32'(exp_d));
    exp_v = m_pend && !rst;
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_v && m_pend_who == 0));
    check("dma_rvalid", 32'(dma_rvalid), 32'(exp_v && m_pend_who == 1));
    check("cpu_rdata", 32'(cpu_rdata), (exp_v && m_pend_who == 0) ? 32'(m_pend_data) : 32'd0);
    check("dma_rdata", 32'(dma_rdata), (exp_v && m_pend_who == 1) ? 32'(m_pend_data) : 32'd0);
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
    $display("t=%0t rst=%0d creq=%0d dreq=%0d win=%0d we=%0d addr=%0d conf=%0d",
             $time, rst, c_act, d_act, win, exp_we, exp_a, m_conf);
    last_win = win;
    if (rst) begin
      m_owner = 1; m_streak = 0; m_conf = 0; m_pend = 0;
    end else begin
      if (both && m_conf < 255) m_conf++;
      m_pend = 0;
      if (win >= 0) begin
        if (win == m_owner) m_streak++;
        else begin m_owner = win; m_streak = 1; end
        if (!exp_we) begin
          m_pend = 1; m_pend_who = win; m_pend_data = ref_mem[exp_a];
        end else begin
          ref_mem[exp_a] = exp_d;
        end
      end
      if (win == 0) c_act = 0;
      if (win == 1) d_act = 0;
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask

  initial begin
    reset = 1; load_en = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    c_act = 0; d_act = 0; c_we = 0; d_we = 0;
    c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(8'h10 + i);
    m_owner = 1; m_streak = 0; m_conf = 0; m_pend = 0; m_pend_who = 0;
    m_pend_data = '0; last_win = -1;

    // 1: CPU-only reads of the preloaded words
    reset_cycles(2);
    load_en = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_issue(0, 5'(i), 8'h00);
      step(0);
    end
    step(0);

    // 2: continuous contention from reset
    reset_cycles(1);
    for (int i = 0; i < 12; i++) begin
      cpu_issue(0, 5'($urandom_range(0, 31)), 8'h00);
      dma_issue(0, 5'($urandom_range(0, 31)), 8'h00);
      step(0);
      check("rr_order", 32'(last_win), 32'((i / 4) % 2));
    end
    @(posedge clk); #1;
    check("conf12", 32'(conflict_cnt), 32'd12);
    c_act = 0; d_act = 0;

    // 3: DMA write then CPU read-back
    reset_cycles(1);
    dma_issue(1, 5'd7, 8'hA5);
    step(0);
    cpu_issue(0, 5'd7, 8'h00);
    step(0);
    step(0);

    // 4: alternating single reads
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cpu_issue(0, 5'($urandom_range(0, 31)), 8'h00);
      else            dma_issue(0, 5'($urandom_range(0, 31)), 8'h00);
      step(0);
    end
    step(0);

    // 5: reset right after a CPU read grant
    cpu_issue(0, 5'd3, 8'h00);
    step(0);
    check("pre_rst_win", 32'(last_win), 32'd0);
    step(1);
    cpu_issue(0, 5'd1, 8'h00);
    dma_issue(0, 5'd2, 8'h00);
    step(0);
    check("post_rst_win", 32'(last_win), 32'd0);
    step(0);

    // 6: saturation of the conflict counter
    for (int i = 0; i < 300; i++) begin
      cpu_issue(0, 5'($urandom_range(0, 31)), 8'h00);
      dma_issue(1, 5'($urandom_range(0, 31)), 8'($urandom));
      step(0);
    end
    @(posedge clk); #1;
    check("conf_sat", 32'(conflict_cnt), 32'd255);
    c_act = 0; d_act = 0;

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0)
        cpu_issue(1'($urandom), 5'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0)
        dma_issue(1'($urandom), 5'($urandom), 8'($urandom));
      step($urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
